// File: rtl/kalman_fx_pkg.sv
// Shared fixed-point definitions for the Kalman update datapath.
//   WIDTH / INT_DIGITS : default word format (signed, INT_DIGITS integer bits
//                        including sign, FRAC fractional bits).
//   fx_t / mat2_t      : scalar word and 2x2 matrix of words.
//   fx_sat / fx_ovf    : rescale a full-precision accumulator back to fx_t,
//                        saturating at the fx_t range, and flag saturation.
package kalman_fx_pkg;

  localparam int WIDTH      = 16;
  localparam int INT_DIGITS = 10;
  localparam int FRAC       = WIDTH - INT_DIGITS;
  localparam int ACC_W      = 2 * WIDTH + 1;

  typedef logic signed [WIDTH-1:0]   fx_t;
  typedef fx_t [0:1][0:1]            mat2_t;
  typedef logic signed [2*WIDTH-1:0] prod_t;
  typedef logic signed [ACC_W-1:0]   acc_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MAC  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam fx_t FX_MAX = fx_t'((2 ** (WIDTH - 1)) - 1);
  localparam fx_t FX_MIN = fx_t'(-(2 ** (WIDTH - 1)));

  // True when the rescaled accumulator falls outside the fx_t range.
  function automatic logic fx_ovf(input acc_t acc);
    acc_t sh;
    sh = acc >>> FRAC;
    return (sh > acc_t'(FX_MAX)) || (sh < acc_t'(FX_MIN));
  endfunction

  // Arithmetic shift (floor) back to FRAC fractional bits, then clamp.
  function automatic fx_t fx_sat(input acc_t acc);
    acc_t sh;
    sh = acc >>> FRAC;
    if (sh > acc_t'(FX_MAX)) begin
      return FX_MAX;
    end else if (sh < acc_t'(FX_MIN)) begin
      return FX_MIN;
    end
    return fx_t'(sh);
  endfunction

endpackage

// File: rtl/kalman_gain_mult_2x2_fx_mac.sv
// Single shared multiply-accumulate unit for the 2x2 gain multiplier.
// Ports:
//   clk, rst   : clock, asynchronous active-high reset (clears the accumulator)
//   clk_en     : advance enable; accumulator holds when low
//   clr        : zero the accumulator (new operation)
//   step       : perform a MAC step this edge
//   first      : step loads the product instead of adding it (k = 0 term)
//   a, b       : operands for this step
//   res        : saturated, rescaled value of the accumulator after this step
//   ovf        : res was clamped
module kalman_gain_mult_2x2_fx_mac
  import kalman_fx_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic clk_en,
  input  logic clr,
  input  logic step,
  input  logic first,
  input  fx_t  a,
  input  fx_t  b,
  output fx_t  res,
  output logic ovf
);

  prod_t prod;
  acc_t  acc_d;
  acc_t  acc_q;

  always_comb begin
    prod  = a * b;
    acc_d = acc_q;
    if (clr) begin
      acc_d = '0;
    end else if (step) begin
      if (first) begin
        acc_d = acc_t'(prod);
      end else begin
        acc_d = acc_q + acc_t'(prod);
      end
    end
    // Result is taken from the next accumulator value so the finished
    // element can be written on the same edge as its second product.
    res = fx_sat(acc_d);
    ovf = fx_ovf(acc_d);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q <= '0;
    end else if (clk_en) begin
      acc_q <= acc_d;
    end
  end

endmodule

// File: rtl/kalman_gain_mult_2x2.sv
// Sequential 2x2 fixed-point matrix multiply Res = A * B, computing the
// Kalman gain K = (P*H^T) * S^-1 downstream of the 2x2 inverter.
// One shared MAC performs 8 steps per operation (two per output element).
// Ports:
//   clk, rst : clock, asynchronous active-high reset
//   clk_en   : advance enable; low freezes all state
//   start    : request, accepted only in IDLE
//   A, B     : operands, latched on the accepted start edge
//   Res      : product matrix, elements update progressively, then hold
//   done     : high for the DONE state (one enabled cycle)
//   busy     : high in MAC and DONE
//   sat      : sticky saturation flag for the current operation
module kalman_gain_mult_2x2
  import kalman_fx_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  clk_en,
  input  logic  start,
  input  mat2_t A,
  input  mat2_t B,
  output mat2_t Res,
  output logic  done,
  output logic  busy,
  output logic  sat
);

  state_t     state_d, state_q;
  logic [2:0] idx_d, idx_q;
  mat2_t      a_d, a_q;
  mat2_t      b_d, b_q;
  mat2_t      res_d, res_q;
  logic       sat_d, sat_q;
  logic       done_d, done_q;
  logic       busy_d, busy_q;

  logic mac_clr;
  logic mac_step;
  fx_t  mac_a;
  fx_t  mac_b;
  fx_t  mac_res;
  logic mac_ovf;

  // idx[2] = row i, idx[1] = column j, idx[0] = inner index k.
  assign mac_a = a_q[idx_q[2]][idx_q[0]];
  assign mac_b = b_q[idx_q[0]][idx_q[1]];

  kalman_gain_mult_2x2_fx_mac u_mac (
    .clk    (clk),
    .rst    (rst),
    .clk_en (clk_en),
    .clr    (mac_clr),
    .step   (mac_step),
    .first  (~idx_q[0]),
    .a      (mac_a),
    .b      (mac_b),
    .res    (mac_res),
    .ovf    (mac_ovf)
  );

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    a_d      = a_q;
    b_d      = b_q;
    res_d    = res_q;
    sat_d    = sat_q;
    mac_clr  = 1'b0;
    mac_step = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          a_d     = A;
          b_d     = B;
          idx_d   = 3'd0;
          sat_d   = 1'b0;
          mac_clr = 1'b1;
          state_d = ST_MAC;
        end
      end
      ST_MAC: begin
        mac_step = 1'b1;
        idx_d    = idx_q + 3'd1;
        if (idx_q[0]) begin
          res_d[idx_q[2]][idx_q[1]] = mac_res;
          if (mac_ovf) begin
            sat_d = 1'b1;
          end
        end
        if (idx_q == 3'd7) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Status outputs are registered copies of the next state.
    done_d = (state_d == ST_DONE);
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      idx_q   <= 3'd0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      sat_q   <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else if (clk_en) begin
      state_q <= state_d;
      idx_q   <= idx_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      sat_q   <= sat_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  assign Res  = res_q;
  assign done = done_q;
  assign busy = busy_q;
  assign sat  = sat_q;

endmodule
